gpio_seg7_display: RTL and testbench

Downstream consumer of the CPU's 32-bit GPIO output register: captures each value the CPU writes to its display port and drives the eight active-low seven-segment digits (HEX0..HEX7) on the board. Supports raw hexadecimal display (one-cycle update) and unsigned decimal display via a sequential 32-iteration shift-add-3 binary-to-BCD converter. Sits between the CPU's display GPIO write port and the top-level HEX pins; a one-deep pending slot absorbs writes that arrive mid-conversion.

---
 rtl/gpio_seg7_display_if.sv | 9 +
 rtl/gpio_seg7_display.sv | 132 +++++++++++++
 tb/tb_gpio_seg7_display.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gpio_seg7_display_if.sv
// gpio_seg7_display_if: CPU display-port write bus into the seven-segment driver
interface gpio_seg7_display_if;
  logic [31:0] value_in;
  logic        value_we;
  logic        dec_mode;
  logic        busy;
  modport master(output value_in, value_we, dec_mode, input busy);
  modport slave(input value_in, value_we, dec_mode, output busy);
endinterface

// File: rtl/gpio_seg7_display.sv
// gpio_seg7_display: hex or shift-add-3 decimal display of GPIO writes on eight active-low digits
module gpio_seg7_display #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  gpio_seg7_display_if.slave         bus,
  output logic [6:0]                 HEX0,
  output logic [6:0]                 HEX1,
  output logic [6:0]                 HEX2,
  output logic [6:0]                 HEX3,
  output logic [6:0]                 HEX4,
  output logic [6:0]                 HEX5,
  output logic [6:0]                 HEX6,
  output logic [6:0]                 HEX7,
  output logic                       overflow
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      r_state;
  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [4:0]  r_cnt;
  logic        r_dec;
  logic        r_pend;
  logic [31:0] r_pend_val;
  logic        r_pend_dec;
  logic        r_busy;
  logic        r_ovf;
  logic [6:0]  r_hex [8];
  logic [39:0] w_adj;
  logic [71:0] w_sh;
  logic [6:0]  w_enc [8];
  logic [3:0]  w_nib;
  logic        w_zero;
  logic        w_ovf;
  logic        w_go;
  logic [31:0] w_src_val;
  logic        w_src_dec;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  // a new value is accepted from idle, or from done when either a fresh write or the pending slot is available;
  // a fresh write in done beats the pending slot (last write wins)
  assign w_go      = (r_state == IDLE && bus.value_we) || (r_state == DONE && (bus.value_we || r_pend));
  assign w_src_val = bus.value_we ? bus.value_in : r_pend_val;
  assign w_src_dec = bus.value_we ? bus.dec_mode : r_pend_dec;
  assign w_ovf     = r_dec & (|r_bcd[39:32]);
  assign w_sh      = {w_adj, r_bin} << 1;

  // add-3 correction of every BCD nibble that would overflow on the next shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 10; i++)
      w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end

  // segment encode from the top digit down so leading-zero blanking can be tracked in one pass
  always_comb begin
    w_zero = 1'b1;
    w_nib  = '0;
    for (int i = 7; i >= 0; i--) begin
      w_nib    = r_dec ? r_bcd[4*i +: 4] : r_bin[4*i +: 4];
      w_zero   = w_zero & (w_nib == 4'd0);
      w_enc[i] = w_ovf ? 7'h3F : (r_dec && BLANK_LZ && i != 0 && w_zero) ? 7'h7F : seg(w_nib);
    end
  end

  // control FSM: capture, iterate the converter, publish results only in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_dec      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_pend_dec <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < 8; i++) r_hex[i] <= 7'h7F;
    end else begin
      case (r_state)
        SHIFT: begin
          r_bcd <= w_sh[71:32];
          r_bin <= w_sh[31:0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= DONE;
          if (bus.value_we) begin
            r_pend     <= 1'b1;
            r_pend_val <= bus.value_in;
            r_pend_dec <= bus.dec_mode;
          end
        end
        DONE: begin
          for (int i = 0; i < 8; i++) r_hex[i] <= w_enc[i];
          r_ovf   <= w_ovf;
          r_pend  <= 1'b0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_go) begin
        r_bin   <= w_src_val;
        r_dec   <= w_src_dec;
        r_bcd   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
        r_state <= w_src_dec ? SHIFT : DONE;
      end
    end
  end

  assign bus.busy = r_busy;
  assign overflow = r_ovf;
  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];
  assign HEX6 = r_hex[6];
  assign HEX7 = r_hex[7];
endmodule

// File: tb/tb_gpio_seg7_display.sv
// tb_gpio_seg7_display: directed vectors against a timing-level arithmetic model of the display
module tb_gpio_seg7_display;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic started = 1'b0;
  logic [6:0] h [8];
  logic ovf;
  int pass = 0;
  int total = 0;

  gpio_seg7_display_if bus();

  gpio_seg7_display #(.BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .HEX0(h[0]), .HEX1(h[1]), .HEX2(h[2]), .HEX3(h[3]),
    .HEX4(h[4]), .HEX5(h[5]), .HEX6(h[6]), .HEX7(h[7]),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [55:0] act;
  always_comb act = {h[7], h[6], h[5], h[4], h[3], h[2], h[1], h[0]};

  function automatic logic [55:0] disp(input logic [31:0] v, input logic dec);
    logic [55:0] r;
    longint p;
    p = 1;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      if (!dec) r[7*n +: 7] = SEG[(v >> (4*n)) & 32'hF];
      else if (v >= 32'd100000000) r[7*n +: 7] = 7'h3F;
      else if (n > 0 && longint'(v) < p) r[7*n +: 7] = 7'h7F;
      else r[7*n +: 7] = SEG[(longint'(v) / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  logic [55:0] m_disp;
  logic        m_busy, m_ovf, m_dec, m_pend, m_pend_dec;
  logic [31:0] m_val, m_pend_val;
  int          m_t;

  // model: m_t counts cycles until the in-flight value appears (33 decimal, 1 hex)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_pend <= 1'b0; m_busy <= 1'b0; m_ovf <= 1'b0; m_disp <= {8{7'h7F}};
    end else if (m_t == 0) begin
      if (bus.value_we) begin
        m_val <= bus.value_in; m_dec <= bus.dec_mode; m_t <= bus.dec_mode ? 33 : 1; m_busy <= 1'b1;
      end
    end else if (m_t == 1) begin
      m_disp <= disp(m_val, m_dec);
      m_ovf  <= m_dec && m_val >= 32'd100000000;
      m_pend <= 1'b0;
      if (bus.value_we) begin
        m_val <= bus.value_in; m_dec <= bus.dec_mode; m_t <= bus.dec_mode ? 33 : 1;
      end else if (m_pend) begin
        m_val <= m_pend_val; m_dec <= m_pend_dec; m_t <= m_pend_dec ? 33 : 1;
      end else begin
        m_t <= 0; m_busy <= 1'b0;
      end
    end else begin
      m_t <= m_t - 1;
      if (bus.value_we) begin
        m_pend <= 1'b1; m_pend_val <= bus.value_in; m_pend_dec <= bus.dec_mode;
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else pass++;
  endtask

  always @(negedge clk)
    if (started) chk("cycle", {act, bus.busy, ovf}, {m_disp, m_busy, m_ovf});

  task automatic wr(input logic [31:0] v, input logic d);
    @(negedge clk);
    bus.value_in = v; bus.dec_mode = d; bus.value_we = 1'b1;
    @(negedge clk);
    bus.value_we = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("busy_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    int n;
    bus.value_in = '0; bus.dec_mode = 1'b0; bus.value_we = 1'b0;
    #2 rst_n = 1'b0;
    #1 started = 1'b1;
    #9 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hex", act, {8{7'h7F}});
    chk("rst_busy_ovf", {bus.busy, ovf}, 2'b00);
    chk("model_1e8", disp(32'd100000000, 1'b1), {8{7'h3F}});
    chk("model_dec7", disp(32'd7, 1'b1), {{7{7'h7F}}, 7'h78});

    wr(32'hDEADBEEF, 1'b0);
    chk("hex_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("hex_deadbeef", act, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
    chk("hex_idle", bus.busy, 1'b0);

    wr(32'd2, 1'b1);
    wait_idle(n);
    chk("dec_latency", 64'(n), 64'd33);
    chk("dec_2", act, {{7{7'h7F}}, 7'h24});

    wr(32'd12345678, 1'b1);
    wait_idle(n);
    chk("dec_12345678", act, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});

    wr(32'd100000000, 1'b1);
    wait_idle(n);
    chk("dec_ovf_hex", act, {8{7'h3F}});
    chk("dec_ovf_flag", ovf, 1'b1);

    wr(32'd0, 1'b1);
    wait_idle(n);
    chk("dec_zero", act, {{7{7'h7F}}, 7'h40});
    chk("dec_zero_ovf", ovf, 1'b0);

    wr(32'd5, 1'b1);
    repeat (8) @(negedge clk);
    wr(32'd7, 1'b1);
    repeat (8) @(negedge clk);
    wr(32'd9, 1'b1);
    repeat (13) @(negedge clk);
    chk("pend_first_5", {act, bus.busy}, {{7{7'h7F}}, 7'h12, 1'b1});
    repeat (33) @(negedge clk);
    chk("pend_last_9", {act, bus.busy}, {{7{7'h7F}}, 7'h10, 1'b0});

    wr(32'd42, 1'b1);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {act, bus.busy, ovf}, {{8{7'h7F}}, 2'b00});
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_42", {act, bus.busy}, {{8{7'h7F}}, 1'b0});
    wr(32'h1, 1'b0);
    @(negedge clk);
    chk("hex_after_rst", act, {{7{7'h40}}, 7'h79});

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass, total);
    $fatal(1);
  end
endmodule
